id_stage_riscv: RTL

Decode/operand stage directly upstream of the integer ALU. It accepts one 32-bit RV32I instruction per handshake and decodes the R-type (OP) and I-type (OP-IMM) arithmetic formats. It reads the operands from an internal 32×32 register file and registers the ALU operand bundle (`in1`, `in2`, `func3`, `opequal`) behind a valid/ready interface. Results return from writeback through a single write port.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/regfile_riscv.sv | 62 ++++++
 rtl/id_stage_riscv.sv | 124 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I decode constants for the decode/operand stage.
package riscv_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned NREG_DEFAULT = 32;
    localparam int unsigned REG_AW       = 5;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SLL  = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SR   = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } func3_e;

endpackage

// File: rtl/regfile_riscv.sv
// regfile_riscv: 2-read / 1-write register file, x0 hardwired to zero.
// Optional same-cycle write-to-read forwarding under `RV_WB_BYPASS_EN.
module regfile_riscv
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT,
    parameter int unsigned NREG = NREG_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] i_raddr1,
    input  logic [REG_AW-1:0] i_raddr2,
    output logic [XLEN-1:0]   o_rdata1,
    output logic [XLEN-1:0]   o_rdata2,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [XLEN-1:0]   i_wdata
);

    logic [XLEN-1:0] r_regs [NREG];
    logic            w_wr;

    assign w_wr = i_we && (i_waddr != '0);

    // Architectural state; reset clears everything and drops a same-cycle write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Read port 1, x0 forced to zero.
    always_comb begin
        o_rdata1 = '0;
        if (i_raddr1 != '0) begin
            o_rdata1 = r_regs[i_raddr1];
        end
`ifdef RV_WB_BYPASS_EN
        if (w_wr && (i_waddr == i_raddr1)) begin
            o_rdata1 = i_wdata;
        end
`endif
    end

    // Read port 2, x0 forced to zero.
    always_comb begin
        o_rdata2 = '0;
        if (i_raddr2 != '0) begin
            o_rdata2 = r_regs[i_raddr2];
        end
`ifdef RV_WB_BYPASS_EN
        if (w_wr && (i_waddr == i_raddr2)) begin
            o_rdata2 = i_wdata;
        end
`endif
    end

endmodule

// File: rtl/id_stage_riscv.sv
// id_stage_riscv: RV32I OP / OP-IMM decode, operand read and ALU bundle register.
// Config macro: RV_WB_BYPASS_EN enables same-cycle writeback forwarding in regfile_riscv.
module id_stage_riscv
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT,
    parameter int unsigned NREG = NREG_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    output logic              instr_ready,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              alu_valid,
    input  logic              alu_ready,
    output logic [XLEN-1:0]   in1,
    output logic [XLEN-1:0]   in2,
    output logic [2:0]        func3,
    output logic              opequal,
    output logic [REG_AW-1:0] rd,
    output logic              illegal
);

    logic [6:0]        w_opcode;
    logic [2:0]        w_func3;
    logic [REG_AW-1:0] w_rs1;
    logic [REG_AW-1:0] w_rs2;
    logic [REG_AW-1:0] w_rd;
    logic              w_is_op;
    logic              w_is_opimm;
    logic              w_legal;
    logic              w_acc;
    logic [XLEN-1:0]   w_rdata1;
    logic [XLEN-1:0]   w_rdata2;
    logic [XLEN-1:0]   w_imm;
    logic [XLEN-1:0]   w_in2;
    logic              w_opequal;

    logic              r_alu_valid;
    logic [XLEN-1:0]   r_in1;
    logic [XLEN-1:0]   r_in2;
    logic [2:0]        r_func3;
    logic              r_opequal;
    logic [REG_AW-1:0] r_rd;
    logic              r_illegal;

    assign w_opcode   = instr[6:0];
    assign w_rd       = instr[11:7];
    assign w_func3    = instr[14:12];
    assign w_rs1      = instr[19:15];
    assign w_rs2      = instr[24:20];
    assign w_is_op    = (w_opcode == OPC_OP);
    assign w_is_opimm = (w_opcode == OPC_OPIMM);
    assign w_legal    = w_is_op || w_is_opimm;

    // Single pipeline register: accept whenever the slot is empty or being drained.
    assign instr_ready = !r_alu_valid || alu_ready;
    assign w_acc       = instr_valid && instr_ready;

    regfile_riscv #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .i_raddr1 (w_rs1),
        .i_raddr2 (w_rs2),
        .o_rdata1 (w_rdata1),
        .o_rdata2 (w_rdata2),
        .i_we     (wb_en),
        .i_waddr  (wb_rd),
        .i_wdata  (wb_data)
    );

    // Operand 2 source and SUB/SRA select; ADDI and friends never raise opequal.
    always_comb begin
        w_imm     = {{(XLEN-12){instr[31]}}, instr[31:20]};
        w_in2     = w_imm;
        w_opequal = 1'b0;
        if (w_is_op) begin
            w_in2     = w_rdata2;
            w_opequal = instr[30];
        end else if (w_func3 == F3_SR) begin
            w_opequal = instr[30];
        end
    end

    // Bundle register, valid flag and one-cycle illegal-opcode pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_valid <= 1'b0;
            r_in1       <= '0;
            r_in2       <= '0;
            r_func3     <= '0;
            r_opequal   <= 1'b0;
            r_rd        <= '0;
            r_illegal   <= 1'b0;
        end else begin
            r_illegal <= w_acc && !w_legal;
            if (w_acc && w_legal) begin
                r_alu_valid <= 1'b1;
                r_in1       <= w_rdata1;
                r_in2       <= w_in2;
                r_func3     <= w_func3;
                r_opequal   <= w_opequal;
                r_rd        <= w_rd;
            end else if (alu_ready) begin
                r_alu_valid <= 1'b0;
            end
        end
    end

    assign alu_valid = r_alu_valid;
    assign in1       = r_in1;
    assign in2       = r_in2;
    assign func3     = r_func3;
    assign opequal   = r_opequal;
    assign rd        = r_rd;
    assign illegal   = r_illegal;

endmodule
